// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, one even-parity bit.
// Presents the assembled word with a one-cycle valid strobe and a parity flag.
module sipo_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;

  // Bit ordering is fixed at elaboration: the first data bit ends up at the
  // MSB after WIDTH shifts when shifting left, at the LSB when shifting right.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], in};
    end else begin : g_lsb_first
      assign shift_next = {in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: default the strobe low each cycle so it can only pulse once.
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in) begin
            state   <= DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        DATA: begin
          shift_reg <= shift_next;
          if (bit_cnt == LAST_BIT) begin
            state <= PARITY;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          // A parity failure still delivers the word; only the flag reports it.
          data_out   <= shift_reg;
          parity_err <= (^shift_reg) ^ in;
          data_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
